// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, the A10-high address,
// the auto-refresh FSM state type and the per-step command decode.
// Optional feature macro: SDRAM_AREF_DOUBLE_EN (second AREF at step 5,
// sequence length 11 instead of 7).
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0]  CMD_NOP  = 4'b0111;
  localparam logic [3:0]  CMD_PALL = 4'b0010;
  localparam logic [3:0]  CMD_AREF = 4'b0001;
  localparam logic [3:0]  CMD_MRS  = 4'b0000;

  // A10 high selects "all banks" for PALL
  localparam logic [12:0] ADDR_A10 = 13'h0400;

`ifdef SDRAM_AREF_DOUBLE_EN
  localparam int AREF_CMD_END = 11;
`else
  localparam int AREF_CMD_END = 7;
`endif

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } aref_state_t;

  // Command issued for a given step of the granted sequence
  function automatic logic [3:0] aref_step_cmd(input logic [3:0] step);
    logic [3:0] cmd;
    case (step)
      4'd0:    cmd = CMD_PALL;
      4'd1:    cmd = CMD_AREF;
`ifdef SDRAM_AREF_DOUBLE_EN
      4'd5:    cmd = CMD_AREF;
`endif
      default: cmd = CMD_NOP;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/sdram_aref_if.sv
// Handshake and command bus between the auto-refresh generator and the
// controller arbiter / init block.
interface sdram_aref_if;
  logic        flag_init_end;
  logic        ref_en;
  logic        ref_req;
  logic        flag_ref_end;
  logic [3:0]  aref_cmd;
  logic [12:0] aref_addr;
  logic        ref_overrun;

  // Refresh generator side
  modport slave (
    input  flag_init_end,
    input  ref_en,
    output ref_req,
    output flag_ref_end,
    output aref_cmd,
    output aref_addr,
    output ref_overrun
  );

  // Arbiter / init side
  modport master (
    output flag_init_end,
    output ref_en,
    input  ref_req,
    input  flag_ref_end,
    input  aref_cmd,
    input  aref_addr,
    input  ref_overrun
  );
endinterface

// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh generator. Times the refresh interval once
// initialisation is done, requests the bus, and on grant plays out a
// PALL + AREF sequence. Macro SDRAM_AREF_DOUBLE_EN adds a second AREF.
module sdram_aref
  import sdram_pkg::*;
#(
  parameter int DELAY_78US = 390,
  parameter int CMD_END    = AREF_CMD_END
) (
  input  logic          clk,
  input  logic          rst_n,
  sdram_aref_if.slave   bus
);

  localparam int REF_W = $clog2(DELAY_78US);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(DELAY_78US - 1);
  localparam logic [3:0]       CMD_LAST = 4'(CMD_END - 1);

  aref_state_t      r_state;
  logic [REF_W-1:0] r_cnt_ref;
  logic [3:0]       r_cnt_cmd;
  logic [3:0]       r_aref_cmd;
  logic [12:0]      r_aref_addr;
  logic             r_flag_ref_end;
  logic             r_ref_req;
  logic             r_ref_overrun;

  logic w_end_ref;
  logic w_accept;

  // Interval end and grant acceptance (grant ignored outside IDLE)
  always_comb begin
    w_end_ref = 1'b0;
    w_accept  = 1'b0;
    if (bus.flag_init_end && (r_cnt_ref == REF_LAST)) begin
      w_end_ref = 1'b1;
    end else begin
      w_end_ref = 1'b0;
    end
    if ((r_state == ST_IDLE) && r_ref_req && bus.ref_en) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
  end

  // Free-running refresh interval counter, held at 0 until init is done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_ref <= '0;
    end else if (!bus.flag_init_end) begin
      r_cnt_ref <= '0;
    end else if (r_cnt_ref == REF_LAST) begin
      r_cnt_ref <= '0;
    end else begin
      r_cnt_ref <= r_cnt_ref + 1'b1;
    end
  end

  // Request and sticky overrun; a coincident interval end re-arms the request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_req     <= 1'b0;
      r_ref_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_ref_req <= w_end_ref;
      end else if (w_end_ref) begin
        r_ref_req <= 1'b1;
      end else begin
        r_ref_req <= r_ref_req;
      end
      if (w_end_ref && r_ref_req && !w_accept) begin
        r_ref_overrun <= 1'b1;
      end else begin
        r_ref_overrun <= r_ref_overrun;
      end
    end
  end

  // Sequence FSM with registered command, address and end pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt_cmd      <= 4'd0;
      r_aref_cmd     <= CMD_NOP;
      r_aref_addr    <= ADDR_A10;
      r_flag_ref_end <= 1'b0;
    end else begin
      r_aref_addr <= ADDR_A10;
      case (r_state)
        ST_IDLE: begin
          r_aref_cmd     <= CMD_NOP;
          r_flag_ref_end <= 1'b0;
          r_cnt_cmd      <= 4'd0;
          if (w_accept) begin
            r_state <= ST_ACTIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (r_cnt_cmd == CMD_LAST) begin
            r_state        <= ST_IDLE;
            r_cnt_cmd      <= 4'd0;
            r_aref_cmd     <= CMD_NOP;
            r_flag_ref_end <= 1'b1;
          end else begin
            r_state        <= ST_ACTIVE;
            r_cnt_cmd      <= r_cnt_cmd + 4'd1;
            r_aref_cmd     <= aref_step_cmd(r_cnt_cmd);
            r_flag_ref_end <= 1'b0;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_cnt_cmd      <= 4'd0;
          r_aref_cmd     <= CMD_NOP;
          r_flag_ref_end <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ref_req      = r_ref_req;
  assign bus.flag_ref_end = r_flag_ref_end;
  assign bus.aref_cmd     = r_aref_cmd;
  assign bus.aref_addr    = r_aref_addr;
  assign bus.ref_overrun  = r_ref_overrun;

endmodule

// File: doc/sdram_aref.md
# sdram_aref

Periodic auto-refresh generator for the SDRAM controller; sits directly downstream of the power-up initialisation block and consumes its `flag_init_end`. After initialisation completes it times the 7.8 µs refresh interval, raises a request to the controller arbiter, and, once granted, drives a PALL + AREF command sequence onto its own command/address outputs. The arbiter muxes `aref_cmd`/`aref_addr` to the SDRAM pins while the refresh is active.

## Interface
- `DELAY_78US`, 390: refresh interval in clk cycles (50 MHz).
- `CMD_END`, 7: length of the granted command sequence in cycles (11 when `SDRAM_AREF_DOUBLE_EN` is defined).
- `clk`, input, 1: system clock. All logic is on a single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `flag_init_end`, input, 1: level from the init block; high once initialisation is done.
- `ref_en`, input, 1: grant from the arbiter; sampled only while `ref_req` = 1.
- `ref_req`, output, 1: refresh request to the arbiter.
- `flag_ref_end`, output, 1: one-cycle pulse marking the end of the sequence.
- `aref_cmd`, output, 4: {cs_n, ras_n, cas_n, we_n}.
- `aref_addr`, output, 13: SDRAM address bus value.
- `ref_overrun`, output, 1: sticky; a refresh interval elapsed while a request was still pending.

## Operation
- **Command encodings:**
  - NOP = 4'b0111
  - PALL = 4'b0010
  - AREF = 4'b0001
- **Address:** `aref_addr` is always 13'h0400 (A10 = 1), including during PALL.
- **Interval counter `cnt_ref`:**
  - Counts only while `flag_init_end` = 1; otherwise it holds at 0.
  - Counts 0..DELAY_78US-1 and wraps to 0.
  - `end_ref` = counting && `cnt_ref` == DELAY_78US-1.
  - The counter free-runs and is never paused by an active refresh.
- **FSM states:** IDLE and ACTIVE.
  - IDLE → ACTIVE when `ref_req` && `ref_en`. This is the "accept" event. On the same edge, `cnt_cmd` is cleared to 0.
  - ACTIVE → IDLE on the edge where `cnt_cmd` == CMD_END-1.
- **Step counter `cnt_cmd`:**
  - Advances by 1 per cycle in ACTIVE.
  - `aref_cmd` is registered from `cnt_cmd`: step 0 gives PALL, step 1 gives AREF, all other steps give NOP.
  - On the last step, `aref_cmd` returns to NOP and `flag_ref_end` is set for exactly one cycle.
  - In IDLE, `aref_cmd` = NOP.
- **`ref_req`:**
  - Set on `end_ref`; cleared on accept.
  - If `end_ref` and accept coincide, `ref_req` stays 1 (a new request) and `ref_overrun` is not set.
- **`ref_overrun`:** set when `end_ref` occurs while `ref_req` is already 1 and there is no accept that cycle. It clears only on reset.
- **Refresh request during ACTIVE:** an `end_ref` while in ACTIVE sets `ref_req` normally. The new request is not accepted until the FSM has returned to IDLE; `ref_en` is ignored while in ACTIVE.
- **Drop of `flag_init_end`:** if `flag_init_end` falls (it should not), `cnt_ref` holds at 0. A request already pending and a sequence already in progress both complete normally.

## Timing
- **Reset values:**
  - `aref_cmd` = NOP, `aref_addr` = 13'h0400
  - `ref_req` = 0, `flag_ref_end` = 0, `ref_overrun` = 0
  - FSM = IDLE, both counters = 0
- **First request:** `ref_req` rises on the edge where `cnt_ref` reaches DELAY_78US-1, i.e. DELAY_78US cycles after the first edge on which `flag_init_end` is sampled high.
- **Grant sequence,** with edge E0 as the accept edge:
  - E0: `ref_req` goes to 0.
  - E1: `aref_cmd` = PALL.
  - E2: `aref_cmd` = AREF.
  - E(CMD_END): `flag_ref_end` = 1 and the FSM is back in IDLE. `flag_ref_end` returns to 0 at E(CMD_END+1).
- **Earliest next accept:** E(CMD_END), i.e. when `ref_en` is sampled in IDLE.
- **Grant latency:** minimum 1 cycle from `ref_req` high to accept. There is no maximum; `ref_req` is held until granted.
- **Asynchronous reset mid-sequence:** returns all outputs to their reset values immediately. No partial sequence resumes after reset.

## Configuration
- **Macro:** `SDRAM_AREF_DOUBLE_EN`.
- **When defined:**
  - A second AREF is issued at step 5 (tRC spacing).
  - `CMD_END` defaults to 11.
  - `flag_ref_end` fires at E11.
- **When undefined:**
  - A single AREF is issued at step 1.
  - `CMD_END` defaults to 7.
  - Step 5 decodes to NOP.

## Structure
- **Shared package `sdram_pkg`:**
  - Command constants NOP, PALL, AREF and MRS.
  - The A10-high address constant 13'h0400.
  - The FSM state typedef.
- **Sub-modules:** none. Both counters and the FSM are inline.

## Test plan
- **Reset and init gating:** hold `flag_init_end` = 0 for 1000 cycles → `ref_req` = 0, `aref_cmd` = 4'b0111, `aref_addr` = 13'h0400.
- **First request:** raise `flag_init_end`; `ref_en` = 0 → `ref_req` rises after exactly 390 cycles and stays high.
- **Granted sequence:** pulse `ref_en` for 1 cycle while `ref_req` = 1 → PALL at E1, AREF at E2, NOP at E3–E7, `flag_ref_end` high only at E7. With `SDRAM_AREF_DOUBLE_EN`: AREF at E2 and E6, `flag_ref_end` at E11.
- **Overrun:** never grant for 800 cycles → `ref_overrun` = 1 from the second interval end onward. A subsequent grant still runs a normal sequence.
- **Coincident events:** drive `ref_en` = 1 exactly at the edge where `cnt_ref` = 389 while `ref_req` is pending → sequence starts, `ref_req` remains 1, `ref_overrun` stays 0.
- **Reset mid-sequence:** assert `rst_n` = 0 at E2 → `aref_cmd` = NOP immediately. After release, no PALL/AREF appears until a new `ref_req`/`ref_en` handshake.
